// File: rtl/mem_arbiter_rr.sv
// N-port arbiter funnelling cache/scratchpad requesters onto one cpu_ram-style RAM port.
// Round-robin or fixed-priority selection with bounded burst hold and error return.
module mem_arbiter_rr #(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ARB_MODE  = 0,
   parameter int BURST_MAX = 1
) (
   input  logic                         CLK,
   input  logic                         nrst,
   input  logic [NUM_REQ-1:0]           req_ren,
   input  logic [NUM_REQ-1:0]           req_wen,
   input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]    req_store,
   output logic [NUM_REQ-1:0]           req_wait,
   output logic [NUM_REQ-1:0]           req_err,
   output logic [DATA_W-1:0]            req_load,
   output logic                         ram_ren,
   output logic                         ram_wen,
   output logic [ADDR_W-1:0]            ram_addr,
   output logic [DATA_W-1:0]            ram_store,
   input  logic [DATA_W-1:0]            ram_load,
   input  logic [1:0]                   ram_state,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         grant_vld
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = 4;

   localparam logic [1:0] RS_ACCESS = 2'b10;
   localparam logic [1:0] RS_ERROR  = 2'b11;

   typedef enum logic {ST_ARB, ST_OWN} state_e;

   state_e             state_q;
   logic [ID_W-1:0]    grant_id_q;
   logic [ID_W-1:0]    last_grant_q;
   logic               grant_vld_q;
   logic [CNT_W-1:0]   burst_cnt_q;

   logic [NUM_REQ-1:0] act;
   logic               hold;
   logic [ID_W-1:0]    rr_id;
   logic [ID_W-1:0]    fp_id;
   logic [ID_W-1:0]    win_id;
   logic               in_own;
   logic               own_act;
   logic               own_ren;
   logic               own_wen;
   logic               done;
   logic [ADDR_W-1:0]  own_addr;
   logic [DATA_W-1:0]  own_store;

   assign act = req_ren | req_wen;

   // Winner selection; burst_cnt_q == 0 means no owner has been granted since reset.
   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      hold  = (burst_cnt_q != '0) && act[grant_id_q] &&
              (burst_cnt_q < CNT_W'(BURST_MAX));
      rr_id = '0;
      fp_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (act[i] && (ID_W'(i) <= last_grant_q)) rr_id = ID_W'(i);
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (act[i] && (ID_W'(i) > last_grant_q)) rr_id = ID_W'(i);
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (act[i]) fp_id = ID_W'(i);
      end
      if (hold)               win_id = grant_id_q;
      else if (ARB_MODE == 1) win_id = fp_id;
      else                    win_id = rr_id;
   end

   always_comb begin
      own_addr  = '0;
      own_store = '0;
      own_ren   = 1'b0;
      own_wen   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_W'(i)) begin
            own_addr  = req_addr[i*ADDR_W +: ADDR_W];
            own_store = req_store[i*DATA_W +: DATA_W];
            own_ren   = req_ren[i];
            own_wen   = req_wen[i];
         end
      end
   end

   assign in_own  = (state_q == ST_OWN);
   assign own_act = own_ren | own_wen;
   assign done    = in_own && own_act &&
                    ((ram_state == RS_ACCESS) || (ram_state == RS_ERROR));

   // RAM side follows the owner combinationally, so an abort or reset drops enables at once.
   assign ram_wen   = in_own & own_wen;
   assign ram_ren   = in_own & own_ren & ~own_wen;
   assign ram_addr  = in_own ? own_addr  : '0;
   assign ram_store = in_own ? own_store : '0;
   assign req_load  = ram_load;

   always_comb begin
      req_wait = act;
      req_err  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (done && (grant_id_q == ID_W'(i))) begin
            req_wait[i] = 1'b0;
            req_err[i]  = (ram_state == RS_ERROR);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_ARB;
         grant_vld_q  <= 1'b0;
         grant_id_q   <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         burst_cnt_q  <= '0;
      end else begin
         case (state_q)
            ST_ARB: begin
               if (|act) begin
                  state_q     <= ST_OWN;
                  grant_vld_q <= 1'b1;
                  grant_id_q  <= win_id;
                  burst_cnt_q <= hold ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
               end
            end
            ST_OWN: begin
               // Completion or owner abort both hand the port back for re-arbitration.
               if (!own_act || done) begin
                  state_q     <= ST_ARB;
                  grant_vld_q <= 1'b0;
                  if (done) last_grant_q <= grant_id_q;
               end
            end
            default: begin
               state_q     <= ST_ARB;
               grant_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign grant_id  = grant_id_q;
   assign grant_vld = grant_vld_q;

endmodule
